// File: rtl/sev_seg_pkg.sv
// Shared constants and types for the switch/ALU/seven-segment design.
// Holds clock rate, debounce default and the debounce FSM state type.
package sev_seg_pkg;

  localparam int unsigned CLK_FREQ_HZ     = 100_000_000;
  localparam int unsigned DEBOUNCE_CYCLES = 1_000_000;

  typedef enum logic {
    DB_STABLE,
    DB_PENDING
  } db_state_t;

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: 2-flop synchronizer, stability counter, two-state
// FSM, registered clean level and registered rise/fall pulses.
//
// Ports:
//   clk      system clock
//   resetn   async active-low reset
//   sw_raw   raw asynchronous switch pin
//   clean_o  debounced level
//   rise_o   1-cycle pulse on clean 0->1
//   fall_o   1-cycle pulse on clean 1->0
module sw_debounce_bit
  import sev_seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic resetn,
  input  logic sw_raw,
  output logic clean_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic            sync1_q;
  logic            sync2_q;
  db_state_t       state_q;
  db_state_t       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic            clean_q;
  logic            clean_d;
  logic            rise_q;
  logic            rise_d;
  logic            fall_q;
  logic            fall_d;
  logic            differ;

  assign differ = (sync2_q != clean_q);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sw_raw;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= DB_STABLE;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // The first differing cycle already counts as one, so the clean
  // level flips after exactly STABLE_CYCLES differing cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clean_d = clean_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      DB_STABLE: begin
        cnt_d = '0;
        if (differ) begin
          state_d = DB_PENDING;
          cnt_d   = CNT_ONE;
        end
      end
      DB_PENDING: begin
        if (!differ) begin
          state_d = DB_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DB_STABLE;
          cnt_d   = '0;
          clean_d = sync2_q;
          rise_d  = sync2_q;
          fall_d  = ~sync2_q;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = DB_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign clean_o = clean_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/sw_debounce.sv
// Debounces a bank of slide switches, one independent lane per bit.
// Ports: clk, resetn (async low), sw_raw -> sw_clean, sw_rise,
// sw_fall (1-cycle pulses) and sw_changed (OR of all pulses).
module sw_debounce
  import sev_seg_pkg::*;
#(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned STABLE_CYCLES = DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sw_debounce_bit #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_bit (
      .clk    (clk),
      .resetn (resetn),
      .sw_raw (sw_raw[i]),
      .clean_o(sw_clean[i]),
      .rise_o (sw_rise[i]),
      .fall_o (sw_fall[i])
    );
  end

  assign sw_changed = |(sw_rise | sw_fall);

endmodule

// File: tb/tb_sw_debounce.sv
// Self-checking bench for sw_debounce with a window-based
// reference model.
module tb_sw_debounce;

  localparam int W  = 16;
  localparam int SC = 4;

  logic         clk;
  logic         resetn;
  logic [W-1:0] sw_raw;
  logic [W-1:0] sw_clean;
  logic [W-1:0] sw_rise;
  logic [W-1:0] sw_fall;
  logic         sw_changed;

  int errors;
  int checks;

  sw_debounce #(
    .WIDTH(W),
    .STABLE_CYCLES(SC)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .sw_raw    (sw_raw),
    .sw_clean  (sw_clean),
    .sw_rise   (sw_rise),
    .sw_fall   (sw_fall),
    .sw_changed(sw_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: raw is seen two edges late; a bit flips once the
  // last SC seen values all disagree with its current clean level.
  logic [W-1:0] rawq[$];
  logic [W-1:0] seenq[$];
  logic [W-1:0] m_clean;
  logic [W-1:0] m_rise;
  logic [W-1:0] m_fall;

  function automatic logic [W-1:0] model_next(
    input logic [W-1:0] raw, input logic [W-1:0] cur);
    logic [W-1:0] seen;
    logic [W-1:0] nc;
    bit all_diff;
    seen = (rawq.size() == 2) ? rawq[0] : '0;
    rawq.push_back(raw);
    if (rawq.size() > 2) void'(rawq.pop_front());
    seenq.push_back(seen);
    if (seenq.size() > SC) void'(seenq.pop_front());
    nc = cur;
    if (seenq.size() == SC) begin
      for (int b = 0; b < W; b++) begin
        all_diff = 1'b1;
        for (int k = 0; k < SC; k++)
          if (seenq[k][b] == cur[b]) all_diff = 1'b0;
        if (all_diff) nc[b] = ~cur[b];
      end
    end
    return nc;
  endfunction

  logic [W-1:0] m_nxt;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rawq.delete();
      seenq.delete();
      m_clean <= '0;
      m_rise  <= '0;
      m_fall  <= '0;
    end else begin
      m_nxt = model_next(sw_raw, m_clean);
      m_rise  <= m_nxt & ~m_clean;
      m_fall  <= ~m_nxt & m_clean;
      m_clean <= m_nxt;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [W-1:0] raw);
    @(negedge clk);
    resetn = 1'b0;
    sw_raw = raw;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset('0);
    checks++;
    if (sw_clean !== '0 || sw_rise !== '0 ||
        sw_fall !== '0 || sw_changed !== 1'b0) begin
      errors++;
      $display("FAIL reset_state clean=%h rise=%h fall=%h chg=%b want 0",
               sw_clean, sw_rise, sw_fall, sw_changed);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (sw_clean !== '0 || sw_changed !== 1'b0 ||
          sw_rise !== '0 || sw_fall !== '0) begin
        errors++;
        $display("FAIL idle c%0d clean=%h chg=%b want 0 0",
                 i, sw_clean, sw_changed);
      end
    end
  endtask

  task automatic test_clean_step();
    sw_raw = 16'h0001;
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++;
      if (sw_clean[0] !== (i >= 6) ||
          sw_rise[0] !== (i == 6) ||
          sw_changed !== (i == 6)) begin
        errors++;
        $display("FAIL step c%0d clean=%b rise=%b chg=%b want %b %b %b",
                 i, sw_clean[0], sw_rise[0], sw_changed,
                 i >= 6, i == 6, i == 6);
      end
    end
  endtask

  task automatic test_bounce();
    logic pat[$];
    pat = '{1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    foreach (pat[k]) begin
      sw_raw[3] = pat[k];
      tick();
      checks++;
      if (sw_clean[3] !== 1'b0 || sw_rise[3] !== 1'b0 ||
          sw_fall[3] !== 1'b0) begin
        errors++;
        $display("FAIL bounce c%0d clean=%b rise=%b want 0 0",
                 k, sw_clean[3], sw_rise[3]);
      end
    end
    sw_raw[3] = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      checks++;
      if (sw_clean[3] !== (i >= 6) || sw_rise[3] !== (i == 6)) begin
        errors++;
        $display("FAIL bounce_hold c%0d clean=%b rise=%b want %b %b",
                 i, sw_clean[3], sw_rise[3], i >= 6, i == 6);
      end
    end
  endtask

  task automatic test_multi_bit();
    do_reset('0);
    repeat (4) tick();
    sw_raw = 16'h00FF;
    for (int i = 1; i <= 7; i++) begin
      tick();
      checks++;
      if (sw_clean !== ((i >= 6) ? 16'h00FF : 16'h0000) ||
          sw_rise !== ((i == 6) ? 16'h00FF : 16'h0000) ||
          sw_changed !== (i == 6)) begin
        errors++;
        $display("FAIL multi_rise c%0d clean=%h rise=%h chg=%b",
                 i, sw_clean, sw_rise, sw_changed);
      end
    end
    sw_raw = 16'h0000;
    for (int i = 1; i <= 7; i++) begin
      tick();
      checks++;
      if (sw_clean !== ((i >= 6) ? 16'h0000 : 16'h00FF) ||
          sw_fall !== ((i == 6) ? 16'h00FF : 16'h0000) ||
          sw_rise !== 16'h0000 ||
          sw_changed !== (i == 6)) begin
        errors++;
        $display("FAIL multi_fall c%0d clean=%h fall=%h chg=%b",
                 i, sw_clean, sw_fall, sw_changed);
      end
    end
  endtask

  task automatic test_reset_high();
    do_reset(16'h8001);
    for (int i = 1; i <= 7; i++) begin
      tick();
      checks++;
      if (sw_clean !== ((i >= 6) ? 16'h8001 : 16'h0000) ||
          sw_rise !== ((i == 6) ? 16'h8001 : 16'h0000)) begin
        errors++;
        $display("FAIL reset_high c%0d clean=%h rise=%h",
                 i, sw_clean, sw_rise);
      end
    end
  endtask

  task automatic test_reset_mid_pending();
    // bit 0 is already clean high from the previous test
    sw_raw = 16'h0021;
    repeat (4) tick();
    #3 resetn = 1'b0;
    #1;
    checks++;
    if (sw_clean !== '0 || sw_rise !== '0 || sw_changed !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset clean=%h rise=%h chg=%b want 0",
               sw_clean, sw_rise, sw_changed);
    end
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 resetn = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      checks++;
      if (sw_clean !== ((i >= 6) ? 16'h0021 : 16'h0000) ||
          sw_rise !== ((i == 6) ? 16'h0021 : 16'h0000)) begin
        errors++;
        $display("FAIL requalify c%0d clean=%h rise=%h",
                 i, sw_clean, sw_rise);
      end
    end
  endtask

  task automatic test_random();
    int hold;
    logic [W-1:0] flip;
    for (int seg = 0; seg < 120; seg++) begin
      flip = W'($urandom) & W'($urandom);
      sw_raw = sw_raw ^ flip;
      hold = $urandom_range(1, 8);
      for (int c = 0; c < hold; c++) begin
        tick();
        checks++;
        if (sw_clean !== m_clean || sw_rise !== m_rise ||
            sw_fall !== m_fall ||
            sw_changed !== |(m_rise | m_fall)) begin
          errors++;
          $display("FAIL random s%0d clean=%h/%h rise=%h/%h fall=%h/%h",
                   seg, sw_clean, m_clean, sw_rise, m_rise,
                   sw_fall, m_fall);
        end
      end
    end
    sw_raw = 16'hFFFF;
    for (int c = 0; c < 10; c++) begin
      sw_raw = ~sw_raw;
      tick();
      checks++;
      if (sw_clean !== m_clean || sw_changed !== |(m_rise | m_fall)) begin
        errors++;
        $display("FAIL toggle c%0d clean=%h want %h",
                 c, sw_clean, m_clean);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    resetn = 1'b0;
    sw_raw = '0;
    test_reset();
    test_clean_step();
    test_bounce();
    test_multi_bit();
    test_reset_high();
    test_reset_mid_pending();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sw_debounce.md
Name: sw_debounce

Overview:
Input conditioning stage that sits between the board slide switches (SW[15:0]) and the ALU/seven-segment top. Each switch bit is passed through a two-flop synchronizer, then debounced by a per-bit stability counter. The block outputs clean, glitch-free switch levels plus one-cycle rise/fall pulses. The top level feeds a/b/s from sw_clean instead of the raw pins.

Parameters:
WIDTH, 16, number of switch bits conditioned.
STABLE_CYCLES, 1_000_000, consecutive cycles a synchronized input must differ from sw_clean before sw_clean changes (10 ms at 100 MHz); must be >= 2.
CNT_W, $clog2(STABLE_CYCLES), counter width (derived, not overridden).

Ports:
clk  input  1  system clock, 100 MHz (CLK100MHZ at top).
resetn  input  1  asynchronous, active-low reset (CPU_RESETN at top).
sw_raw  input  WIDTH  raw asynchronous switch pins.
sw_clean  output  WIDTH  debounced switch levels.
sw_rise  output  WIDTH  one-cycle pulse per bit when sw_clean bit goes 0->1.
sw_fall  output  WIDTH  one-cycle pulse per bit when sw_clean bit goes 1->0.
sw_changed  output  1  OR of (sw_rise | sw_fall), same cycle.

Behaviour:
- Reset (resetn low, async): sync flops = 0, sw_clean = 0, all counters = 0, sw_rise = sw_fall = 0, sw_changed = 0. Outputs stay at these values while resetn is low.
- Synchronizer: sync1 <= sw_raw; sync2 <= sync1; two flops per bit, no logic between them.
- Per-bit FSM, two states:
  - STABLE: sync2 == sw_clean; counter held at 0.
  - PENDING: sync2 != sw_clean; counter increments by 1 each cycle.
- Transitions:
  - STABLE -> PENDING when sync2 != sw_clean.
  - PENDING -> STABLE with counter cleared whenever sync2 == sw_clean (bounce rejected; no output change).
  - PENDING with counter == STABLE_CYCLES-1 and sync2 still != sw_clean: next cycle sw_clean <= sync2, counter <= 0, state STABLE, matching rise/fall bit = 1 for exactly that one cycle.
- Latency: a clean step on sw_raw reaches sw_clean after 2 + STABLE_CYCLES clock edges.
- Pulses are registered, coincide with the sw_clean update cycle, and are never asserted for two consecutive cycles on the same bit.
- Bits are fully independent. Simultaneous qualifying changes on several bits pulse in the same cycle, and sw_changed is a single 1-cycle pulse.
- Counter never wraps: it is cleared on qualification or on bounce and cannot exceed STABLE_CYCLES-1.
- Switches already high at reset release are adopted 2 + STABLE_CYCLES cycles later and produce sw_rise pulses. This is intended.
- Reset asserted mid-PENDING discards the count. No pulse is produced.
- sw_raw toggling every cycle (or at any period shorter than STABLE_CYCLES) never changes sw_clean.

Decomposition:
- Shared package sev_seg_pkg:
  - CLK_FREQ_HZ = 100_000_000.
  - DEBOUNCE_CYCLES = 1_000_000 (default for STABLE_CYCLES).
  - typedef enum logic {DB_STABLE, DB_PENDING} db_state_t.
- Sub-module sw_debounce_bit: one bit's synchronizer, counter, FSM, clean flop and rise/fall flops, with parameter STABLE_CYCLES.
- sw_debounce instantiates WIDTH copies in a generate loop and ORs the pulses into sw_changed.

Test Plan (STABLE_CYCLES = 4 for simulation):
- Reset with sw_raw = 16'h0000, release, hold 20 cycles -> sw_clean = 0, no pulses, sw_changed never high.
- Clean step sw_raw[0] 0->1 at cycle T -> sw_clean[0] = 1 at T+6; sw_rise[0] high for exactly cycle T+6; sw_changed high for that cycle only.
- Bounce on bit 3: raw high 2 cycles, low 1, high 2, low -> sw_clean[3] stays 0 and no pulses. Then hold high 6+ cycles -> rise after 6 cycles from the final edge.
- sw_raw = 16'h00FF from 16'h0000 in one cycle -> sw_clean = 16'h00FF on the same cycle; sw_rise = 16'h00FF for one cycle. Then 16'h00FF -> 16'h0000 -> sw_fall = 16'h00FF for one cycle.
- Reset release with sw_raw = 16'h8001 -> 6 cycles later sw_clean = 16'h8001 and sw_rise = 16'h8001 pulse.
- Bit 5 PENDING at counter = 2, assert resetn low async mid-cycle -> sw_clean = 0 immediately, no pulse. After release, a new full 6-cycle qualification is required.
